// File: rtl/piso_serializer_if.sv
// ---------------------------------------------------------------------------
// Module   : piso_serializer_if
// Purpose  : Word-load handshake, bit strobe and serial/status bundle for piso_serializer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

interface piso_serializer_if #(
  parameter int WIDTH = 8
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] p_in;
  logic             in_valid;
  logic             in_ready;
  logic             shift_en;
  logic             serial_out;
  logic             ser_valid;
  logic [WIDTH-1:0] q_parallel_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] bit_cnt;

  // Producer / line-driver side.
  modport master (
    output p_in, in_valid, shift_en,
    input  in_ready, serial_out, ser_valid, q_parallel_out, busy, done, bit_cnt
  );

  // Serializer side.
  modport slave (
    input  p_in, in_valid, shift_en,
    output in_ready, serial_out, ser_valid, q_parallel_out, busy, done, bit_cnt
  );
endinterface

`default_nettype wire

// File: rtl/piso_serializer.sv
// ---------------------------------------------------------------------------
// Module   : piso_serializer
// Purpose  : Parametrised PISO shift register with valid/ready load, bit counter, done pulse.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1,
  parameter bit FILL      = 1'b0
) (
  input  wire logic         clk,
  input  wire logic         clear,
  piso_serializer_if.slave  bus
);

  localparam int                CNT_W  = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  c_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_q;
  logic [CNT_W-1:0] r_cnt;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_shifted;
  logic             w_serial;
  logic             w_last;
  logic             w_end;
  logic             w_ready;

  generate
    if (LSB_FIRST) begin : g_lsb_first
      assign w_shifted = {FILL, r_q[WIDTH-1:1]};
      assign w_serial  = r_q[0];
    end else begin : g_msb_first
      assign w_shifted = {r_q[WIDTH-2:0], FILL};
      assign w_serial  = r_q[WIDTH-1];
    end
  endgenerate

  assign w_last  = (r_cnt == c_LAST);
  assign w_end   = (r_state == SHIFT) && bus.shift_en && w_last;
  // The last-bit cycle accepts the next word so frames stream without a gap.
  assign w_ready = clear && ((r_state == IDLE) || w_end);

  always_ff @(posedge clk) begin
    if (!clear) begin
      r_state <= IDLE;
      r_q     <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_end;
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_q     <= bus.p_in;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (bus.shift_en) begin
            if (w_last) begin
              r_cnt <= '0;
              if (bus.in_valid) begin
                r_q <= bus.p_in;
              end else begin
                r_q     <= w_shifted;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end else begin
              r_q   <= w_shifted;
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = w_ready;
  assign bus.serial_out     = w_serial;
  assign bus.ser_valid      = r_busy;
  assign bus.q_parallel_out = r_q;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.bit_cnt        = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_piso_serializer.sv
// ---------------------------------------------------------------------------
// Module   : tb_piso_serializer
// Purpose  : Self-checking bench for an LSB-first (FILL=0) and an MSB-first (FILL=1) serializer.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_piso_serializer;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  logic         clk = 1'b0;
  logic         clear = 1'b0;
  logic         in_valid = 1'b0;
  logic         shift_en = 1'b0;
  logic [W-1:0] p_in = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_serializer_if #(.WIDTH(W)) ifl ();
  piso_serializer_if #(.WIDTH(W)) ifm ();

  assign ifl.p_in = p_in;  assign ifl.in_valid = in_valid;  assign ifl.shift_en = shift_en;
  assign ifm.p_in = p_in;  assign ifm.in_valid = in_valid;  assign ifm.shift_en = shift_en;

  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b1), .FILL(1'b0)) u_lsb (
    .clk(clk), .clear(clear), .bus(ifl.slave));
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1'b0), .FILL(1'b1)) u_msb (
    .clk(clk), .clear(clear), .bus(ifm.slave));

  // Reference model: the frame word plus how many bits of it have left the register.
  logic [W-1:0] m_word = '0;
  int           m_k    = 0;
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  logic         last_ready_l, last_ready_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] q_lsb(input logic [W-1:0] wd, input int k);
    logic [W-1:0] v;
    v = wd >> k;
    return v;
  endfunction

  function automatic logic [W-1:0] q_msb(input logic [W-1:0] wd, input int k);
    logic [W-1:0] v, ones;
    ones = '1;
    ones = ones << k;
    v = wd << k;
    return v | ~ones;
  endfunction

  task automatic step(input logic c, input logic v, input logic [W-1:0] p, input logic e);
    logic exp_ready, last;
    @(negedge clk);
    clear = c; in_valid = v; p_in = p; shift_en = e;
    #1;
    last      = m_busy && e && (m_k == W - 1);
    exp_ready = c && (!m_busy || last);
    last_ready_l = ifl.in_ready;
    last_ready_m = ifm.in_ready;
    chk("in_ready_lsb", {31'd0, ifl.in_ready}, {31'd0, exp_ready});
    chk("in_ready_msb", {31'd0, ifm.in_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (!c) begin
      m_word = '0; m_k = 0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      m_done = last;
      if (!m_busy) begin
        if (v) begin m_word = p; m_k = 0; m_busy = 1'b1; end
      end else if (e) begin
        if (last && v) begin m_word = p; m_k = 0; end
        else begin
          m_k = m_k + 1;
          if (last) m_busy = 1'b0;
        end
      end
    end
    #1;
    chk("busy_lsb", {31'd0, ifl.busy}, {31'd0, m_busy});
    chk("busy_msb", {31'd0, ifm.busy}, {31'd0, m_busy});
    chk("ser_valid_lsb", {31'd0, ifl.ser_valid}, {31'd0, m_busy});
    chk("ser_valid_msb", {31'd0, ifm.ser_valid}, {31'd0, m_busy});
    chk("done_lsb", {31'd0, ifl.done}, {31'd0, m_done});
    chk("done_msb", {31'd0, ifm.done}, {31'd0, m_done});
    chk("bit_cnt_lsb", 32'(ifl.bit_cnt), m_busy ? 32'(m_k) : 32'd0);
    chk("bit_cnt_msb", 32'(ifm.bit_cnt), m_busy ? 32'(m_k) : 32'd0);
    chk("q_lsb", 32'(ifl.q_parallel_out), 32'(q_lsb(m_word, m_k)));
    chk("q_msb", 32'(ifm.q_parallel_out), 32'(q_msb(m_word, m_k)));
    if (m_busy) begin
      chk("serial_lsb", {31'd0, ifl.serial_out}, {31'd0, m_word[m_k]});
      chk("serial_msb", {31'd0, ifm.serial_out}, {31'd0, m_word[W-1-m_k]});
    end
  endtask

  typedef struct {
    logic         c, v;
    logic [W-1:0] p;
    logic         e;
    logic         eb, ed;
    logic [CW-1:0] ec;
    logic         es;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cyc, busy_cnt, done_cnt;
    logic en;

    // 8'hA5 reads 1,0,1,0,0,1,0,1 in both LSB-first and MSB-first order.
    tbl[0]  = '{1'b1, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd2, 1'b1};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd6, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd7, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};

    // Reset state
    step(1'b0, 1'b1, 8'h55, 1'b1);
    chk("reset_ready", {31'd0, last_ready_l}, 32'd0);
    chk("reset_q", 32'(ifl.q_parallel_out), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);

    // Basic frame, table driven
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].c, tbl[i].v, tbl[i].p, tbl[i].e);
      chk("tbl_busy", {31'd0, ifl.busy}, {31'd0, tbl[i].eb});
      chk("tbl_done_l", {31'd0, ifl.done}, {31'd0, tbl[i].ed});
      chk("tbl_done_m", {31'd0, ifm.done}, {31'd0, tbl[i].ed});
      chk("tbl_cnt", 32'(ifl.bit_cnt), 32'(tbl[i].ec));
      if (tbl[i].eb) begin
        chk("tbl_ser_l", {31'd0, ifl.serial_out}, {31'd0, tbl[i].es});
        chk("tbl_ser_m", {31'd0, ifm.serial_out}, {31'd0, tbl[i].es});
      end
    end

    // Strobe every third cycle: done 24 cycles after load
    step(1'b1, 1'b1, 8'h0F, 1'b0);
    done_cyc = -1;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      en = (cyc % 3 == 0);
      step(1'b1, 1'b0, 8'h00, en);
      if (ifl.done && done_cyc < 0) done_cyc = cyc;
    end
    chk("done_latency", 32'(done_cyc), 32'd24);

    // Back-to-back frames with in_valid held
    busy_cnt = 0; done_cnt = 0;
    for (int i = 0; i <= 16; i++) begin
      step(1'b1, (i <= 8), (i == 0) ? 8'h3C : 8'hC3, 1'b1);
      if (i <= 15 && ifl.ser_valid) busy_cnt++;
      if (ifl.done) done_cnt++;
    end
    chk("stream_busy_cycles", 32'(busy_cnt), 32'd16);
    chk("stream_done_pulses", 32'(done_cnt), 32'd2);
    chk("stream_idle_after", {31'd0, ifl.busy}, 32'd0);

    // Reset mid-frame at bit 4
    step(1'b1, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("mid_cnt", 32'(ifl.bit_cnt), 32'd4);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("mid_rst_busy", {31'd0, ifl.busy}, 32'd0);
    chk("mid_rst_q_l", 32'(ifl.q_parallel_out), 32'd0);
    chk("mid_rst_q_m", 32'(ifm.q_parallel_out), 32'd0);
    chk("mid_rst_done", {31'd0, ifl.done}, 32'd0);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("mid_rst_no_done", {31'd0, ifl.done}, 32'd0);
    step(1'b1, 1'b1, 8'h5A, 1'b0);
    chk("reload_cnt", 32'(ifl.bit_cnt), 32'd0);
    chk("reload_ser", {31'd0, ifl.serial_out}, 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 1'b1);

    // Word offered mid-frame is refused
    step(1'b1, 1'b1, 8'h3C, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 8'hFF, 1'b1);
    chk("midframe_ready", {31'd0, last_ready_l}, 32'd0);
    chk("midframe_q", 32'(ifl.q_parallel_out), 32'h07);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h00, 1'b1);
    chk("midframe_idle", {31'd0, ifl.busy}, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 1) == 1),
           W'($urandom), ($urandom_range(0, 9) < 7));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
